// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit: single-outstanding byte/half/word load-store engine with
// read-modify-write for sub-word stores.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module load_store_unit (
   input  logic        Clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   state_e      state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        req_bad;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic [31:0] st_merge;

   always_comb begin
      req_bad = (req_size == SZ_ILL) ||
                ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   end

   // Lane selection and extension for loads; merge for sub-word stores.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (size_q)
         SZ_BYTE: ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
         default: ld_ext = mem_rdata;
      endcase

      st_merge = mem_rdata;
      if (size_q == SZ_BYTE) begin
         case (addr_q[1:0])
            2'd0:    st_merge[7:0]   = wdata_q[7:0];
            2'd1:    st_merge[15:8]  = wdata_q[7:0];
            2'd2:    st_merge[23:16] = wdata_q[7:0];
            default: st_merge[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         st_merge[31:16] = wdata_q;
      end else begin
         st_merge[15:0] = wdata_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata[15:0];
               if (req_bad) begin
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
                  state_d      = RESP;
               end else if (req_wr && (req_size == SZ_WORD)) begin
                  mem_wdata_d = req_wdata;
                  state_d     = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: state_d = CAP;
         CAP: begin
            if (wr_q) begin
               mem_wdata_d = st_merge;
               state_d     = WR;
            end else begin
               resp_rdata_d = ld_ext;
               resp_err_d   = 1'b0;
               state_d      = RESP;
            end
         end
         WR: begin
            resp_rdata_d = 32'd0;
            resp_err_d   = 1'b0;
            state_d      = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         addr_q       <= 12'd0;
         wdata_q      <= 16'd0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
         mem_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Strobes decode straight from state so reset drops them without a clock.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign mem_we     = ~(state_q == WR);
   assign mem_addr   = addr_q[11:2];
   assign mem_wdata  = mem_wdata_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: Clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: req_valid  input  1  request present.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request this cycle.
REQ-005 SHALL have port: req_wr  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 SHALL have port: req_addr  input  12  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-012 SHALL have port: resp_err  output  1  misaligned or illegal-size request; valid with resp_valid.
REQ-013 SHALL have port: mem_we  output  1  data memory write enable, active-low (0 = write).
REQ-014 SHALL have port: mem_addr  output  10  word address = req_addr[11:2].
REQ-015 SHALL have port: mem_wdata  output  32  write word.
REQ-016 SHALL have port: mem_rdata  input  32  data memory read word; valid the cycle after mem_addr was sampled at a rising edge.

Function
REQ-017 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE with req_valid = 1, latch wr/size/unsigned/addr/wdata at the rising edge.
REQ-019 SHALL transition IDLE -> RESP with resp_err = 1 when size = 11, size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 00; no memory write.
REQ-020 SHALL transition IDLE -> WR for aligned word store, and IDLE -> RD for any other legal request.
REQ-021 SHALL drive mem_addr with latched word address in RD, CAP, WR; RD -> CAP unconditionally.
REQ-022 SHALL, in CAP for a load, select lane by addr[1:0] (little-endian: byte n = bits 8n+7..8n; half at addr[1] = bits 16*addr[1]+15..), extend per req_unsigned to 32 bits, register into resp_rdata, go to RESP.
REQ-023 SHALL, in CAP for a sub-word store, replace only the addressed byte/half of mem_rdata with req_wdata[7:0]/[15:0], register merged word into mem_wdata, go to WR.
REQ-024 SHALL assert mem_we = 0 only while in WR (decoded from state); WR -> RESP; mem_we = 1 in all other states.
REQ-025 SHALL assert resp_valid = 1 only in RESP, exactly one cycle, then RESP -> IDLE; no response backpressure.
REQ-026 SHALL produce latency (rising edges from accepting edge to resp_valid high, accepting edge counted as 1): error 1, word store 2, load 3, sub-word store 4.
REQ-027 SHALL ignore req_valid in all states other than IDLE; back-to-back requests accepted in the IDLE cycle following RESP.
REQ-028 SHALL hold resp_rdata and resp_err stable from RESP until next response update.

Reset
REQ-029 SHALL, while rst = 0, force state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 1, mem_addr 0, mem_wdata 0, independent of Clk.
REQ-030 SHALL, on reset asserted mid-operation (including WR), abandon the request immediately with no write and no response.

Verification
REQ-031 SHALL cover: word 0 = 0x000007D1; load byte addr 0x000 unsigned -> resp_rdata 0x000000D1; signed -> 0xFFFFFFD1; resp_valid 3 edges after accept.
REQ-032 SHALL cover: word 1 = 0x00000FA1; store byte 0xAB at addr 0x005 -> word 1 = 0x0000ABA1, other bytes unchanged, resp_valid after 4 edges, resp_rdata 0.
REQ-033 SHALL cover: word 2 = 0x00001389; load half addr 0x002 signed -> 0x00000000; store half 0x8001 at 0x00A then load half signed at 0x00A -> 0xFFFF8001.
REQ-034 SHALL cover: load word addr 0x006 and half addr 0x001 -> resp_err 1 after 1 edge, mem_we never 0, resp_rdata 0.
REQ-035 SHALL cover: word store 0xDEADBEEF at 0x00C with rst driven 0 during WR -> mem_we 1 immediately, word 3 keeps 0x00000BB9, no resp_valid.
REQ-036 SHALL cover: req_valid held high continuously across three requests -> each accepted only when req_ready = 1, responses in order, none lost or duplicated.
